axil_led_gpio_responder: RTL

AXI4-Lite responder that sits behind the MPSoC PL master port and implements the 4-bit LED GPIO register block plus a small scratch register file used for write/read-back checks. It accepts single-beat AXI4-Lite writes and reads from the PS master, drives the LED outputs from a register, and returns OKAY or SLVERR per access. One write and one read may be in flight at the same time, one of each.

---
 rtl/axil_led_pkg.sv | 29 ++
 rtl/axil_led_blinker.sv | 37 +++
 rtl/axil_led_gpio_responder.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/axil_led_pkg.sv
// Shared constants, register offsets and FSM state types for the AXI4-Lite LED GPIO responder.
package axil_led_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned OFF_LED_DATA     = 'h000;
  localparam int unsigned OFF_BLINK_MASK   = 'h004;
  localparam int unsigned OFF_BLINK_PERIOD = 'h008;
  localparam int unsigned OFF_ID           = 'h00C;
  localparam int unsigned OFF_SCRATCH      = 'h100;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_LED,
    SEL_MASK,
    SEL_PERIOD,
    SEL_ID,
    SEL_SCRATCH
  } reg_sel_e;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/axil_led_blinker.sv
// Blink phase generator: counts cycles up to period-1, then wraps and toggles the phase.
module axil_led_blinker (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] period,
  input  logic        clear,
  output logic        phase
);

  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (clear || (period == '0)) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == period - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/axil_led_gpio_responder.sv
// AXI4-Lite responder for the LED GPIO registers and a scratch register file.
// Define LED_BLINK_EN to add BLINK_MASK/BLINK_PERIOD and the blink generator.
module axil_led_gpio_responder
  import axil_led_pkg::*;
#(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned LED_W         = 4,
  parameter int unsigned SCRATCH_WORDS = 16,
  parameter logic [31:0] ID_VALUE      = 32'h4C454434
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic [3:0]        s_axi_wstrb,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [LED_W-1:0]  led_o
);

  localparam int unsigned WordW = ADDR_W - 2;
  localparam int unsigned IdxW  = $clog2(SCRATCH_WORDS);
  typedef logic [WordW-1:0] word_t;

  function automatic reg_sel_e decode(input word_t w);
    if (w == word_t'(OFF_LED_DATA / 4)) return SEL_LED;
`ifdef LED_BLINK_EN
    if (w == word_t'(OFF_BLINK_MASK / 4)) return SEL_MASK;
    if (w == word_t'(OFF_BLINK_PERIOD / 4)) return SEL_PERIOD;
`endif
    if (w == word_t'(OFF_ID / 4)) return SEL_ID;
    if ((w >= word_t'(OFF_SCRATCH / 4)) && (w < word_t'(OFF_SCRATCH / 4 + SCRATCH_WORDS))) begin
      return SEL_SCRATCH;
    end
    return SEL_NONE;
  endfunction

  // Byte-lane bits of the addresses are ignored by the decoder.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  logic [LED_W-1:0] led_q;
  logic [31:0]      scratch_q [SCRATCH_WORDS];
`ifdef LED_BLINK_EN
  logic [LED_W-1:0] mask_q;
  logic [31:0]      period_q;
  logic             blink_clear;
  logic             phase;
`endif

  // Write channel
  w_state_e    w_state_q, w_state_d;
  logic        aw_held_q, w_held_q;
  word_t       aw_word_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q;

  logic           aw_hs, w_hs, commit, wr_en;
  word_t          wr_word;
  logic [31:0]    wr_data, wr_mask;
  logic [3:0]     wr_strb;
  reg_sel_e       wr_sel;
  logic [IdxW-1:0] wr_idx;
  logic [1:0]     wr_resp;

  assign s_axi_awready = (w_state_q == W_IDLE) && !aw_held_q;
  assign s_axi_wready  = (w_state_q == W_IDLE) && !w_held_q;
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bresp   = bresp_q;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid && s_axi_wready;
  assign wr_word = aw_hs ? s_axi_awaddr[ADDR_W-1:2] : aw_word_q;
  assign wr_data = w_hs ? s_axi_wdata : w_data_q;
  assign wr_strb = w_hs ? s_axi_wstrb : w_strb_q;
  assign wr_mask = strb_mask(wr_strb);
  assign wr_sel  = decode(wr_word);
  assign wr_idx  = wr_word[IdxW-1:0];
  assign commit  = (w_state_q == W_IDLE) && (aw_held_q || aw_hs) && (w_held_q || w_hs);
  assign wr_resp = ((wr_sel == SEL_NONE) || (wr_sel == SEL_ID)) ? RESP_SLVERR : RESP_OKAY;
  assign wr_en   = commit && (wr_resp == RESP_OKAY) && (wr_strb != 4'h0);

  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE: if (commit) w_state_d = W_RESP;
      W_RESP: if (s_axi_bready) w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_word_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      if (aw_hs) begin
        aw_held_q <= 1'b1;
        aw_word_q <= s_axi_awaddr[ADDR_W-1:2];
      end
      if (w_hs) begin
        w_held_q <= 1'b1;
        w_data_q <= s_axi_wdata;
        w_strb_q <= s_axi_wstrb;
      end
      if (commit) begin
        aw_held_q <= 1'b0;
        w_held_q  <= 1'b0;
        bresp_q   <= wr_resp;
      end
    end
  end

  // Register file
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      led_q <= '0;
      for (int unsigned i = 0; i < SCRATCH_WORDS; i++) scratch_q[i] <= '0;
`ifdef LED_BLINK_EN
      mask_q   <= '0;
      period_q <= '0;
`endif
    end else if (wr_en) begin
      case (wr_sel)
        SEL_LED: led_q <= (led_q & ~wr_mask[LED_W-1:0]) | (wr_data[LED_W-1:0] & wr_mask[LED_W-1:0]);
        SEL_SCRATCH: scratch_q[wr_idx] <= (scratch_q[wr_idx] & ~wr_mask) | (wr_data & wr_mask);
`ifdef LED_BLINK_EN
        SEL_MASK: mask_q <= (mask_q & ~wr_mask[LED_W-1:0]) | (wr_data[LED_W-1:0] & wr_mask[LED_W-1:0]);
        SEL_PERIOD: period_q <= (period_q & ~wr_mask) | (wr_data & wr_mask);
`endif
        default: ;
      endcase
    end
  end

  // Read channel
  r_state_e        r_state_q, r_state_d;
  logic [31:0]     rdata_q, rd_word;
  logic [1:0]      rresp_q, rd_resp;
  logic            ar_hs;
  reg_sel_e        rd_sel;
  logic [IdxW-1:0] rd_idx;

  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rdata   = rdata_q;
  assign s_axi_rresp   = rresp_q;

  assign ar_hs  = s_axi_arvalid && s_axi_arready;
  assign rd_sel = decode(s_axi_araddr[ADDR_W-1:2]);
  assign rd_idx = s_axi_araddr[IdxW+1:2];

  // Sampled from current register state, so a same-cycle write commit is not visible.
  always_comb begin
    rd_word = '0;
    rd_resp = RESP_OKAY;
    case (rd_sel)
      SEL_LED:     rd_word = 32'(led_q);
`ifdef LED_BLINK_EN
      SEL_MASK:    rd_word = 32'(mask_q);
      SEL_PERIOD:  rd_word = period_q;
`endif
      SEL_ID:      rd_word = ID_VALUE;
      SEL_SCRATCH: rd_word = scratch_q[rd_idx];
      default:     rd_resp = RESP_SLVERR;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE: if (ar_hs) r_state_d = R_DATA;
      R_DATA: if (s_axi_rready) r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state_q <= R_IDLE;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      r_state_q <= r_state_d;
      if (ar_hs) begin
        rdata_q <= rd_word;
        rresp_q <= rd_resp;
      end
    end
  end

  // LED drive
`ifdef LED_BLINK_EN
  assign blink_clear = wr_en && (wr_sel == SEL_PERIOD);

  axil_led_blinker u_blinker (
    .clk   (ACLK),
    .rst_n (ARESETn),
    .period(period_q),
    .clear (blink_clear),
    .phase (phase)
  );

  assign led_o = led_q ^ (mask_q & {LED_W{phase}});
`else
  assign led_o = led_q;
`endif

endmodule
